// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: in-flight destination record,
// bubble constant and the forward-select width helper.
package forward_scoreboard_pkg;

  // Records carry the widest supported register index; narrower indices are zero-extended.
  localparam int unsigned MAX_REG_W = 8;

  typedef logic [MAX_REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     we;
    logic     is_load;
    reg_idx_t rd;
  } dest_rec_t;

  localparam dest_rec_t BUBBLE_REC = '{valid: 1'b0, we: 1'b0, is_load: 1'b0, rd: '0};

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // True when the record will actually produce a forwardable register value.
  function automatic logic rec_writes(input dest_rec_t rec, input reg_idx_t zero_idx);
    return rec.valid && rec.we && (rec.rd != zero_idx);
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// EX-side bundle between the pipeline control (master) and the forwarding
// scoreboard (slave).
interface forward_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 16
);

  logic                            ex_valid;
  logic [REG_W-1:0]                ex_rd;
  logic                            ex_we;
  logic                            ex_is_load;
  logic [NUM_SRC-1:0][REG_W-1:0]   ex_src;
  logic                            flush;
  logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel;
  logic                            stall;
  logic [CNT_W-1:0]                stall_cnt;

  modport master (
    output ex_valid, ex_rd, ex_we, ex_is_load, ex_src, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_rd, ex_we, ex_is_load, ex_src, flush,
    output fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/forward_scoreboard_src_select.sv
// Priority encoder for one EX source operand: returns k+1 for the youngest
// history slot k that writes the source register, or 0 for the regfile.
module forward_scoreboard_src_select
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned SEL_W    = 2
) (
  input  dest_rec_t [DEPTH-1:0] i_hist,
  input  reg_idx_t              i_src,
  output logic [SEL_W-1:0]      o_sel
);

  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    o_sel = '0;
    if (i_src != ZERO_IDX) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (rec_writes(i_hist[k], ZERO_IDX) && (i_hist[k].rd == i_src)) begin
          o_sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding and load-use hazard unit beside EX: keeps a shift-register history
// of in-flight destinations, drives per-operand bypass selects and a 1-cycle stall.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  forward_scoreboard_if.slave  bus
);

  localparam int unsigned SEL_W    = sel_width(DEPTH);
  localparam reg_idx_t    ZERO_IDX = reg_idx_t'(ZERO_REG);

  dest_rec_t [DEPTH-1:0] r_hist;
  logic [CNT_W-1:0]      r_stall_cnt;

  dest_rec_t             w_ex_rec;
  logic                  w_load_hit;
  logic                  w_stall;
  logic [SEL_W-1:0]      w_sel [NUM_SRC];

  always_comb begin
    w_ex_rec = '{valid:   bus.ex_valid,
                 we:      bus.ex_we,
                 is_load: bus.ex_is_load,
                 rd:      reg_idx_t'(bus.ex_rd)};
  end

  // Only the youngest slot can be a load whose data is not yet available.
  always_comb begin
    w_load_hit = 1'b0;
    if (rec_writes(r_hist[0], ZERO_IDX) && r_hist[0].is_load) begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        if (r_hist[0].rd == reg_idx_t'(bus.ex_src[s])) begin
          w_load_hit = 1'b1;
        end
      end
    end
  end

  assign w_stall = bus.ex_valid && !bus.flush && w_load_hit;

  // A stalled or flushed EX instruction leaves a bubble; older slots keep shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= {DEPTH{BUBBLE_REC}};
    end else begin
      r_hist[0] <= (w_stall || bus.flush) ? BUBBLE_REC : w_ex_rec;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_hist[k] <= r_hist[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    forward_scoreboard_src_select #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_src_select (
      .i_hist (r_hist),
      .i_src  (reg_idx_t'(bus.ex_src[s])),
      .o_sel  (w_sel[s])
    );
  end

  always_comb begin
    bus.fwd_sel = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      bus.fwd_sel[s] = w_sel[s];
    end
  end

  assign bus.stall     = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: default configuration plus a
// NUM_SRC=3 / DEPTH=4 / CNT_W=2 instance for saturation and deep-slot forwarding.
module tb_forward_scoreboard;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  forward_scoreboard_if #(.NUM_SRC(2), .REG_W(5), .SEL_W(2), .CNT_W(16)) bus_a ();
  forward_scoreboard_if #(.NUM_SRC(3), .REG_W(5), .SEL_W(3), .CNT_W(2))  bus_b ();

  forward_scoreboard #(
    .NUM_SRC(2), .DEPTH(3), .REG_W(5), .ZERO_REG(31), .CNT_W(16)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  forward_scoreboard #(
    .NUM_SRC(3), .DEPTH(4), .REG_W(5), .ZERO_REG(31), .CNT_W(2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic fl);
    bus_a.ex_valid   = v;
    bus_a.ex_rd      = rd;
    bus_a.ex_we      = we;
    bus_a.ex_is_load = ld;
    bus_a.ex_src[0]  = s0;
    bus_a.ex_src[1]  = s1;
    bus_a.flush      = fl;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
    bus_b.ex_valid   = v;
    bus_b.ex_rd      = rd;
    bus_b.ex_we      = we;
    bus_b.ex_is_load = ld;
    bus_b.ex_src[0]  = s0;
    bus_b.ex_src[1]  = s1;
    bus_b.ex_src[2]  = s2;
    bus_b.flush      = 1'b0;
  endtask

  initial begin
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    n_cmp  = 0;
    n_fail = 0;

    // Reset state
    reset = 1'b1;
    set_a(1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd4, 1'b0);
    set_b(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("rst_stall", 32'(bus_a.stall), 32'd0);
    check("rst_sel0", 32'(bus_a.fwd_sel[0]), 32'd0);
    check("rst_cnt", 32'(bus_a.stall_cnt), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // 1: ADD x3 ages through the slots, then leaves the window
    set_a(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd10, 1'b1, 1'b0, 5'd3, 5'd7, 1'b0);
    #1;
    check("t1_slot0", 32'(bus_a.fwd_sel[0]), 32'd1);
    check("t1_nomatch", 32'(bus_a.fwd_sel[1]), 32'd0);
    tick();
    set_a(1'b1, 5'd11, 1'b1, 1'b0, 5'd3, 5'd7, 1'b0);
    #1;
    check("t1_slot1", 32'(bus_a.fwd_sel[0]), 32'd2);
    tick();
    set_a(1'b1, 5'd12, 1'b1, 1'b0, 5'd3, 5'd10, 1'b0);
    #1;
    check("t1_slot2", 32'(bus_a.fwd_sel[0]), 32'd3);
    check("t1_src1_slot1", 32'(bus_a.fwd_sel[1]), 32'd2);
    tick();
    check("t1_aged_out", 32'(bus_a.fwd_sel[0]), 32'd0);
    check("t1_src1_slot2", 32'(bus_a.fwd_sel[1]), 32'd3);

    // 2: x23 in slots 0 and 2, youngest priority then we=0 on slot 0
    set_a(1'b1, 5'd23, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd23, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b0, 5'd0, 1'b0, 1'b0, 5'd23, 5'd4, 1'b0);
    #1;
    check("t2_youngest", 32'(bus_a.fwd_sel[0]), 32'd1);
    check("t2_x4", 32'(bus_a.fwd_sel[1]), 32'd2);
    set_a(1'b1, 5'd23, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd23, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b0, 5'd0, 1'b0, 1'b0, 5'd23, 5'd6, 1'b0);
    #1;
    check("t2_we0_skip", 32'(bus_a.fwd_sel[0]), 32'd3);
    check("t2_x6", 32'(bus_a.fwd_sel[1]), 32'd2);

    // 3: LDR x5 then consumer of x5
    set_a(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0);
    #1;
    check("t3_stall", 32'(bus_a.stall), 32'd1);
    check("t3_sel_during", 32'(bus_a.fwd_sel[0]), 32'd1);
    check("t3_cnt_before", 32'(bus_a.stall_cnt), 32'd0);
    tick();
    check("t3_stall_drop", 32'(bus_a.stall), 32'd0);
    check("t3_sel_after", 32'(bus_a.fwd_sel[0]), 32'd2);
    check("t3_cnt_after", 32'(bus_a.stall_cnt), 32'd1);
    tick();
    check("t3_no_restall", 32'(bus_a.stall), 32'd0);
    check("t3_bubble_gap", 32'(bus_a.fwd_sel[0]), 32'd3);
    check("t3_cnt_hold", 32'(bus_a.stall_cnt), 32'd1);

    // 4: load-use killed by flush
    set_a(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd5, 1'b1);
    #1;
    check("t4_flush_nostall", 32'(bus_a.stall), 32'd0);
    check("t4_sel_flush", 32'(bus_a.fwd_sel[1]), 32'd1);
    tick();
    set_a(1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd5, 1'b0);
    #1;
    check("t4_bubble", 32'(bus_a.fwd_sel[0]), 32'd0);
    check("t4_ld_slot1", 32'(bus_a.fwd_sel[1]), 32'd2);
    check("t4_stall", 32'(bus_a.stall), 32'd0);
    check("t4_cnt", 32'(bus_a.stall_cnt), 32'd1);

    // 5: XZR is never forwarded nor a hazard
    set_a(1'b1, 5'd31, 1'b1, 1'b1, 5'd31, 5'd31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_zero_stall", 32'(bus_a.stall), 32'd0);
    end
    check("t5_zero_sel0", 32'(bus_a.fwd_sel[0]), 32'd0);
    check("t5_zero_sel1", 32'(bus_a.fwd_sel[1]), 32'd0);

    // 5b: asynchronous reset in the middle of a stall
    set_a(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    set_a(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0);
    #1;
    check("t5_pre_stall", 32'(bus_a.stall), 32'd1);
    check("t5_pre_sel", 32'(bus_a.fwd_sel[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_stall", 32'(bus_a.stall), 32'd0);
    check("t5_rst_sel", 32'(bus_a.fwd_sel[0]), 32'd0);
    check("t5_rst_cnt", 32'(bus_a.stall_cnt), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("t5_release", 32'(bus_a.stall), 32'd0);
    tick();
    check("t5_release_next", 32'(bus_a.stall), 32'd0);
    set_a(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

    // 6: 2-bit counter saturates over five load-use events
    for (int e = 0; e < 5; e++) begin
      set_b(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      tick();
      set_b(1'b1, 5'd20, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
      #1;
      check("t6_stall", 32'(bus_b.stall), 32'd1);
      tick();
      check("t6_stall_drop", 32'(bus_b.stall), 32'd0);
      tick();
      check("t6_cnt", 32'(bus_b.stall_cnt), 32'(exp_cnt[e]));
    end

    // 6b: deepest slot forwards with select 4
    set_b(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_b(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_b(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_b(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_b(1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd2, 5'd9);
    #1;
    check("t6_b_slot0", 32'(bus_b.fwd_sel[0]), 32'd1);
    check("t6_b_slot1", 32'(bus_b.fwd_sel[1]), 32'd2);
    check("t6_b_slot3", 32'(bus_b.fwd_sel[2]), 32'd4);
    tick();
    check("t6_b_aged_out", 32'(bus_b.fwd_sel[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
